axil_reg_file: RTL
==================

AXIL_REG_FILE -- requirements
Module: axil_reg_file

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI-Lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register and data width; only 32 is supported.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, write-strobe width.
REQ-004 SHALL have parameter NUM_REGS, default 16, register count; must be a power of 2 and at least 2.
REQ-005 SHALL have parameter RO_MASK, default 0 (NUM_REGS bits); bit i=1 makes register i read-only.
REQ-006 SHALL have ports clk in 1 (clock) and rst in 1 (reset): one clock; reset is asynchronous and active-high.
REQ-007 SHALL have s_axil_awaddr in ADDR_WIDTH, s_axil_awprot in 3, s_axil_awvalid in 1, s_axil_awready out 1: write address channel.
REQ-008 SHALL have s_axil_wdata in DATA_WIDTH, s_axil_wstrb in STRB_WIDTH, s_axil_wvalid in 1, s_axil_wready out 1: write data channel.
REQ-009 SHALL have s_axil_bresp out 2, s_axil_bvalid out 1, s_axil_bready in 1: write response channel.
REQ-010 SHALL have s_axil_araddr in ADDR_WIDTH, s_axil_arprot in 3, s_axil_arvalid in 1, s_axil_arready out 1: read address channel.
REQ-011 SHALL have s_axil_rdata out DATA_WIDTH, s_axil_rresp out 2, s_axil_rvalid out 1, s_axil_rready in 1: read data channel.
REQ-012 SHALL have ctrl_o out NUM_REGS*DATA_WIDTH: flattened RW register contents, register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-013 SHALL have status_i in NUM_REGS*DATA_WIDTH: read-only register sources, same packing as ctrl_o.
REQ-014 SHALL have wr_pulse_o out NUM_REGS: one-cycle strobe per successfully written register.

Function
REQ-015 SHALL decode the register index as addr[$clog2(NUM_REGS)+1:2]; addr[1:0] ignored; any set bit above the index field -> out of range.
REQ-016 SHALL hold AW in aw_held and W in w_held, each accepted independently; awready = !aw_held, wready = !w_held.
REQ-017 SHALL execute the write on the first edge with aw_held && w_held && !bvalid, in the same edge setting bvalid and clearing both held flags.
REQ-018 SHALL therefore raise bvalid 2 cycles after AW and W handshake together; bvalid is held with bresp stable until bready.
REQ-019 SHALL, for an in-range RW register, update byte lanes whose wstrb bit is 1, leave other lanes unchanged, and respond bresp=OKAY (00).
REQ-020 SHALL, for a write to a RO_MASK register, leave state unchanged and respond bresp=SLVERR (10).
REQ-021 SHALL, for an out-of-range write, leave state unchanged and respond bresp=DECERR (11).
REQ-022 SHALL assert wr_pulse_o[i] for exactly one cycle, coincident with the first bvalid cycle, only for an OKAY write; wstrb=0 still pulses.
REQ-023 SHALL hold arready = !rvalid and, on AR handshake, register rdata/rresp with rvalid high the next cycle, held until rready.
REQ-024 SHALL return the register for RW reads and status_i sampled at the AR handshake edge for RO reads, both with OKAY.
REQ-025 SHALL return rdata=0 with DECERR for out-of-range reads.
REQ-026 SHALL, when a read and write to the same register complete on the same edge, return the pre-write value.
REQ-027 SHALL ignore awprot and arprot.
REQ-028 SHALL drive ctrl_o continuously from the register array; RO slots read 0.

Reset
REQ-029 SHALL, on rst, clear all registers, aw_held, w_held, bvalid, rvalid, wr_pulse_o, rdata and the resp outputs to 0; awready, wready and arready read 1 after reset.
REQ-030 SHALL discard any transaction in flight when rst asserts mid-operation, with no response issued afterward.

Structure
REQ-031 SHALL take AXI response codes OKAY/EXOKAY/SLVERR/DECERR as localparams from shared package axil_pkg.
REQ-032 SHALL be a single module with no sub-modules; the write and read paths are independent always blocks.

Verification
REQ-033 SHALL cover: AW 0x04 and W 0xDEADBEEF strb 0xF in the same cycle -> bvalid 2 cycles later, bresp 00, ctrl_o reg1=0xDEADBEEF, wr_pulse_o[1] for 1 cycle.
REQ-034 SHALL cover: W first then AW 3 cycles later; reg1=0x11223344 then strb 0x2 data 0xAAAAAAAA -> reg1=0x1122AA44.
REQ-035 SHALL cover: RO_MASK=0x8000, status_i reg15=0x5A5A0001; write 0x3C -> SLVERR, no pulse; read 0x3C -> 0x5A5A0001, OKAY.
REQ-036 SHALL cover: read 0x40 with NUM_REGS=16 -> rdata 0, DECERR; write 0x40 -> DECERR, ctrl_o unchanged.
REQ-037 SHALL cover: bready held low 10 cycles with second AW/W pending -> second write waits, executes after the first B handshake, bresp stable throughout.
REQ-038 SHALL cover: rst asserted while aw_held=1 and rvalid=1 -> all outputs return to reset values, with no B or R after rst deasserts.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions for the slaves in this slice.
// Response codes are driven on bresp/rresp.
package axil_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axil_reg_file.sv
// AXI-Lite register file: NUM_REGS word registers, some read-only (fed from status_i),
// with per-register write strobes and independent write/read paths.
module axil_reg_file
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          s_axil_awaddr,
  input  logic [2:0]                     s_axil_awprot,
  input  logic                           s_axil_awvalid,
  output logic                           s_axil_awready,
  input  logic [DATA_WIDTH-1:0]          s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]          s_axil_wstrb,
  input  logic                           s_axil_wvalid,
  output logic                           s_axil_wready,
  output logic [1:0]                     s_axil_bresp,
  output logic                           s_axil_bvalid,
  input  logic                           s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axil_araddr,
  input  logic [2:0]                     s_axil_arprot,
  input  logic                           s_axil_arvalid,
  output logic                           s_axil_arready,
  output logic [DATA_WIDTH-1:0]          s_axil_rdata,
  output logic [1:0]                     s_axil_rresp,
  output logic                           s_axil_rvalid,
  input  logic                           s_axil_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs_q     [NUM_REGS];
  logic [DATA_WIDTH-1:0] status_arr [NUM_REGS];

  logic                  aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic [NUM_REGS-1:0]   wr_pulse_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic                  wr_fire, ar_fire;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic                  wr_in_range, rd_in_range;
  logic [1:0]            wr_resp_d;
  logic [DATA_WIDTH-1:0] wr_data_d;

  // Any set address bit above the index field selects nothing in this block.
  assign wr_idx      = awaddr_q[IDX_W+1:2];
  assign wr_in_range = (awaddr_q[ADDR_WIDTH-1:IDX_W+2] == '0);
  assign rd_idx      = s_axil_araddr[IDX_W+1:2];
  assign rd_in_range = (s_axil_araddr[ADDR_WIDTH-1:IDX_W+2] == '0);

  assign wr_fire = aw_held_q && w_held_q && !bvalid_q;
  assign ar_fire = s_axil_arvalid && !rvalid_q;

  assign s_axil_awready = !aw_held_q;
  assign s_axil_wready  = !w_held_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = !rvalid_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign wr_pulse_o     = wr_pulse_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign ctrl_o[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? '0 : regs_q[g];
    assign status_arr[g] = status_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    wr_resp_d = OKAY;
    if (!wr_in_range) begin
      wr_resp_d = DECERR;
    end else if (RO_MASK[wr_idx]) begin
      wr_resp_d = SLVERR;
    end
    wr_data_d = regs_q[wr_idx];
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (wstrb_q[b]) wr_data_d[b*8 +: 8] = wdata_q[b*8 +: 8];
    end
  end

  // Write path: AW and W park independently; the write commits once both are held
  // and the previous response has been taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (s_axil_awvalid && !aw_held_q) begin
        aw_held_q <= 1'b1;
        awaddr_q  <= s_axil_awaddr;
      end
      if (s_axil_wvalid && !w_held_q) begin
        w_held_q <= 1'b1;
        wdata_q  <= s_axil_wdata;
        wstrb_q  <= s_axil_wstrb;
      end
      if (bvalid_q && s_axil_bready) begin
        bvalid_q <= 1'b0;
      end
      if (wr_fire) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_resp_d;
        if (wr_resp_d == OKAY) begin
          regs_q[wr_idx]     <= wr_data_d;
          wr_pulse_q[wr_idx] <= 1'b1;
        end
      end
    end
  end

  // Read path samples regs_q before any same-edge write lands, so reads see the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else begin
      if (rvalid_q && s_axil_rready) begin
        rvalid_q <= 1'b0;
      end
      if (ar_fire) begin
        rvalid_q <= 1'b1;
        if (!rd_in_range) begin
          rdata_q <= '0;
          rresp_q <= DECERR;
        end else if (RO_MASK[rd_idx]) begin
          rdata_q <= status_arr[rd_idx];
          rresp_q <= OKAY;
        end else begin
          rdata_q <= regs_q[rd_idx];
          rresp_q <= OKAY;
        end
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_araddr[1:0], awaddr_q[1:0]};

endmodule
